phase_sel_clk_gen: RTL and testbench
====================================

// Module: phase_sel_clk_gen
// PURPOSE
// - Parametrised phase-selectable divided-clock generator: derives slow_clk = fast_clk/DIV (50% duty) with run-time phase offset in fast_clk steps.
// - Sits between the fast sampling clock and the antenna data capture; phase sweeps align sampling to the data eye.
// - Adds a load handshake, range check, glitch-safe phase changes at period boundaries and sampling/period strobes.
// PARAMETERS
// - DIV    6  fast_clk cycles per slow_clk period; even, >=2 (elaboration error otherwise)
// - SLEW   1  1: phase moves one step per period toward target; 0: jumps to target at next period boundary
// - DW     $clog2(DIV)  width of delay fields (derived, not overridden)
// PORTS
// - fast_clk     in   1   sole clock; all logic on posedge
// - rst          in   1   synchronous, active-high reset
// - delay_in     in   DW  requested phase offset, 0..DIV-1
// - delay_load   in   1   1-cycle strobe: capture delay_in as target
// - delay_busy   out  1   applied phase != target
// - delay_cur    out  DW  phase currently applied
// - delay_err    out  1   1-cycle pulse: last load out of range (clamped)
// - slow_clk     out  1   divided clock, registered
// - sample_stb   out  1   1-cycle pulse coincident with slow_clk rising edge
// - period_stb   out  1   1-cycle pulse on cnt wrap (update point)
// BEHAVIOUR
// - Reset: cnt=0, ph=0, tgt=0; slow_clk, sample_stb, period_stb, delay_busy, delay_err = 0; delay_cur = 0.
// - cnt: 0..DIV-1, +1 per cycle, wraps to 0; period_stb registered, asserted the cycle after cnt==DIV-1.
// - slow_clk (registered, 1-cycle latency): next = ((cnt + DIV - ph) mod DIV) < DIV/2.
// - ph=0 after reset: slow_clk rises on the 1st edge after rst deasserts, DIV/2 high, DIV/2 low, repeating.
// - ph=k delays every edge by k fast_clk cycles relative to ph=0.
// - sample_stb = slow_clk next & ~slow_clk (same registered timing as slow_clk).
// - Load: on delay_load, tgt <= delay_in if delay_in < DIV.
//   - Else tgt <= DIV-1 and delay_err=1 next cycle.
//   - A load while busy overwrites tgt (latest wins).
// - Update: only on the cycle cnt==DIV-1; ph register changes at that edge, never mid-period.
//   - SLEW=0: ph <= tgt.
//   - SLEW=1: d=(tgt-ph) mod DIV; d==0 hold; 0<d<=DIV/2 -> ph+1 (mod DIV); else ph-1 (mod DIV).
//   - Wrap: DIV-1 -> 0 on +1; 0 -> DIV-1 on -1.
// - SLEW=1 guarantee: no high or low phase shorter than DIV/2-1 or longer than DIV/2+1 cycles.
// - Load on the update cycle: tgt captures new value; update uses the pre-load tgt (register value).
// - delay_busy = (ph != tgt), registered from post-update values; delay_cur = ph.
// - Reset mid-operation: all state returns to reset values next cycle; pending target discarded.
// - Arithmetic: all mod-DIV ops in DW+1 bits, then reduced; no reliance on power-of-two DIV.
// STRUCTURE
// - Shared defines header tart_clkgen_defs.vh: DIV default, clog2 macro, SLEW mode codes.
// - One sub-module clk_phase_slew: holds tgt/ph, load, range check, SLEW stepping.
//   - Inputs: update enable (cnt==DIV-1), delay_in, delay_load. Outputs: ph, busy, err.
// - Top: cnt, slow_clk/strobe generation, instantiation.
// TESTING
// - Reset, DIV=6: slow_clk 1,1,1,0,0,0 repeating from 1st post-reset edge; sample_stb every 6 cycles on rises.
// - DIV=6, SLEW=0, load 2: after next period_stb, slow_clk rises 2 cycles later than before; busy clears with the update.
// - DIV=6, SLEW=1, ph=0, load 5: ph steps 0->5 in one period (-1 wrap); busy high exactly one period boundary.
// - DIV=8, SLEW=1, ph=0, load 4: ph 1,2,3,4 on successive boundaries; every high/low run is 3..5 cycles.
// - DIV=6, load 7 (>=DIV): delay_err one cycle, tgt=5.
// - Load on the update cycle: old tgt is applied and the new value is applied at the following boundary.
// - Reset asserted mid-slew: slow_clk=0 and delay_cur=0 next cycle; waveform matches post-reset pattern.

Source files
------------

// File: rtl/phase_sel_clk_gen_pkg.sv
// Shared constants and helpers for the phase-selectable divided-clock generator.
package phase_sel_clk_gen_pkg;

  // Default fast_clk cycles per slow_clk period.
  localparam int unsigned DefDiv = 6;

  // Phase update modes for the SLEW parameter.
  localparam int unsigned SlewJump = 0;  // jump straight to target at a period boundary
  localparam int unsigned SlewStep = 1;  // move one step per period toward target

  // A 50% duty divided clock needs an even divisor of at least two.
  function automatic bit div_valid(input int unsigned div);
    return (div >= 2) && ((div % 2) == 0);
  endfunction

endpackage

// File: rtl/phase_sel_clk_gen_slew.sv
// Phase target/applied-phase tracker: captures load requests with range clamping and
// moves the applied phase toward the target only at period boundaries.
module phase_sel_clk_gen_slew
  import phase_sel_clk_gen_pkg::*;
#(
  parameter int unsigned DIV  = DefDiv,
  parameter int unsigned SLEW = SlewStep,
  localparam int unsigned DW  = $clog2(DIV)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_update,
  input  logic [DW-1:0] i_delay_in,
  input  logic          i_delay_load,
  output logic [DW-1:0] o_ph,
  output logic          o_busy,
  output logic          o_err
);

  // Modular arithmetic is done one bit wider than DW so DIV itself is representable.
  localparam logic [DW:0]   DivW  = (DW + 1)'(DIV);
  localparam logic [DW:0]   HalfW = (DW + 1)'(DIV / 2);
  localparam logic [DW:0]   OneW  = (DW + 1)'(1);
  localparam logic [DW-1:0] DivM1 = DW'(DIV - 1);

  logic [DW-1:0] r_tgt;
  logic [DW-1:0] r_ph;
  logic          r_busy;
  logic          r_err;

  logic          w_in_range;
  logic [DW:0]   w_diff_raw;
  logic [DW:0]   w_diff;
  logic [DW:0]   w_ph_p1;
  logic [DW-1:0] w_ph_inc;
  logic [DW-1:0] w_ph_dec;
  logic [DW-1:0] w_tgt_d;
  logic [DW-1:0] w_ph_d;

  assign w_in_range = ({1'b0, i_delay_in} < DivW);

  // (tgt - ph) mod DIV, kept non-negative by adding DIV before subtracting.
  assign w_diff_raw = ({1'b0, r_tgt} + DivW) - {1'b0, r_ph};
  assign w_diff     = (w_diff_raw >= DivW) ? (w_diff_raw - DivW) : w_diff_raw;

  assign w_ph_p1  = {1'b0, r_ph} + OneW;
  assign w_ph_inc = (w_ph_p1 == DivW) ? '0 : w_ph_p1[DW-1:0];
  assign w_ph_dec = (r_ph == '0) ? DivM1 : (r_ph - DW'(1));

  // Next target (latest load wins) and next applied phase (boundary-only change).
  always_comb begin
    w_tgt_d = r_tgt;
    if (i_delay_load) begin
      w_tgt_d = w_in_range ? i_delay_in : DivM1;
    end

    // The update works from the registered target, so a load on the update cycle
    // only takes effect at the following boundary.
    w_ph_d = r_ph;
    if (i_update) begin
      if (SLEW == SlewJump) begin
        w_ph_d = r_tgt;
      end else if (w_diff == '0) begin
        w_ph_d = r_ph;
      end else if (w_diff <= HalfW) begin
        w_ph_d = w_ph_inc;
      end else begin
        w_ph_d = w_ph_dec;
      end
    end
  end

  // State registers; busy is derived from post-update values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tgt  <= '0;
      r_ph   <= '0;
      r_busy <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_tgt  <= w_tgt_d;
      r_ph   <= w_ph_d;
      r_busy <= (w_ph_d != w_tgt_d);
      r_err  <= i_delay_load & ~w_in_range;
    end
  end

  assign o_ph   = r_ph;
  assign o_busy = r_busy;
  assign o_err  = r_err;

endmodule

// File: rtl/phase_sel_clk_gen.sv
// Divided-clock generator: slow_clk = fast_clk/DIV at 50% duty with a run-time phase
// offset in fast_clk steps, plus sampling and period strobes.
module phase_sel_clk_gen
  import phase_sel_clk_gen_pkg::*;
#(
  parameter int unsigned DIV  = DefDiv,
  parameter int unsigned SLEW = SlewStep,
  localparam int unsigned DW  = $clog2(DIV)
) (
  input  logic          i_fast_clk,
  input  logic          i_rst,
  input  logic [DW-1:0] i_delay_in,
  input  logic          i_delay_load,
  output logic          o_delay_busy,
  output logic [DW-1:0] o_delay_cur,
  output logic          o_delay_err,
  output logic          o_slow_clk,
  output logic          o_sample_stb,
  output logic          o_period_stb
);

  if (!div_valid(DIV)) begin : g_div_check
    $error("phase_sel_clk_gen: DIV must be even and >= 2");
  end

  localparam logic [DW:0]   DivW  = (DW + 1)'(DIV);
  localparam logic [DW:0]   HalfW = (DW + 1)'(DIV / 2);
  localparam logic [DW-1:0] DivM1 = DW'(DIV - 1);

  logic [DW-1:0] r_cnt;
  logic          r_slow_clk;
  logic          r_sample_stb;
  logic          r_period_stb;

  logic          w_cnt_last;
  logic [DW-1:0] w_ph;
  logic [DW:0]   w_pos_raw;
  logic [DW:0]   w_pos;
  logic          w_slow_d;

  assign w_cnt_last = (r_cnt == DivM1);

  // Position within the phase-shifted period: (cnt - ph) mod DIV.
  assign w_pos_raw = ({1'b0, r_cnt} + DivW) - {1'b0, w_ph};
  assign w_pos     = (w_pos_raw >= DivW) ? (w_pos_raw - DivW) : w_pos_raw;
  assign w_slow_d  = (w_pos < HalfW);

  phase_sel_clk_gen_slew #(
    .DIV  (DIV),
    .SLEW (SLEW)
  ) u_slew (
    .i_clk        (i_fast_clk),
    .i_rst        (i_rst),
    .i_update     (w_cnt_last),
    .i_delay_in   (i_delay_in),
    .i_delay_load (i_delay_load),
    .o_ph         (w_ph),
    .o_busy       (o_delay_busy),
    .o_err        (o_delay_err)
  );

  // Period counter and registered clock/strobe outputs.
  always_ff @(posedge i_fast_clk) begin
    if (i_rst) begin
      r_cnt        <= '0;
      r_slow_clk   <= 1'b0;
      r_sample_stb <= 1'b0;
      r_period_stb <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_last ? '0 : (r_cnt + DW'(1));
      r_slow_clk   <= w_slow_d;
      r_sample_stb <= w_slow_d & ~r_slow_clk;
      r_period_stb <= w_cnt_last;
    end
  end

  assign o_delay_cur  = w_ph;
  assign o_slow_clk   = r_slow_clk;
  assign o_sample_stb = r_sample_stb;
  assign o_period_stb = r_period_stb;

endmodule

// File: tb/tb_phase_sel_clk_gen.sv
// Bench for phase_sel_clk_gen: three instances (DIV6/jump, DIV6/slew, DIV8/slew) checked
// against a cycle-level reference model, a hand-computed vector table and corner sequences.
module tb_phase_sel_clk_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       a_load = 1'b0, b_load = 1'b0, c_load = 1'b0;
  logic [2:0] a_din = '0, b_din = '0, c_din = '0;

  logic       a_busy, a_err, a_slow, a_sstb, a_pstb;
  logic [2:0] a_cur;
  logic       b_busy, b_err, b_slow, b_sstb, b_pstb;
  logic [2:0] b_cur;
  logic       c_busy, c_err, c_slow, c_sstb, c_pstb;
  logic [2:0] c_cur;

  always #5 clk = ~clk;

  phase_sel_clk_gen #(.DIV(6), .SLEW(0)) u_a (
    .i_fast_clk (clk), .i_rst (rst), .i_delay_in (a_din), .i_delay_load (a_load),
    .o_delay_busy (a_busy), .o_delay_cur (a_cur), .o_delay_err (a_err),
    .o_slow_clk (a_slow), .o_sample_stb (a_sstb), .o_period_stb (a_pstb)
  );

  phase_sel_clk_gen #(.DIV(6), .SLEW(1)) u_b (
    .i_fast_clk (clk), .i_rst (rst), .i_delay_in (b_din), .i_delay_load (b_load),
    .o_delay_busy (b_busy), .o_delay_cur (b_cur), .o_delay_err (b_err),
    .o_slow_clk (b_slow), .o_sample_stb (b_sstb), .o_period_stb (b_pstb)
  );

  phase_sel_clk_gen #(.DIV(8), .SLEW(1)) u_c (
    .i_fast_clk (clk), .i_rst (rst), .i_delay_in (c_din), .i_delay_load (c_load),
    .o_delay_busy (c_busy), .o_delay_cur (c_cur), .o_delay_err (c_err),
    .o_slow_clk (c_slow), .o_sample_stb (c_sstb), .o_period_stb (c_pstb)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Reference model: the expected output set after each clock edge.
  typedef struct {
    int cnt;
    int ph;
    int tgt;
    bit slow;
    bit sstb;
    bit pstb;
    bit busy;
    bit err;
  } mdl_t;

  mdl_t m_a, m_b, m_c;

  function automatic mdl_t mstep(input mdl_t m, input int div, input bit slew, input bit r,
                                 input bit ld, input int din);
    mdl_t n;
    int   d;
    bit   nxt;
    n = m;
    if (r) begin
      n = '{default: 0};
      return n;
    end
    nxt    = ((m.cnt + div - m.ph) % div) < (div / 2);
    n.sstb = nxt && !m.slow;
    n.slow = nxt;
    n.pstb = (m.cnt == div - 1);
    n.cnt  = (m.cnt + 1) % div;
    n.err  = ld && (din >= div);
    if (ld) n.tgt = (din < div) ? din : div - 1;
    if (m.cnt == div - 1) begin
      if (!slew) begin
        n.ph = m.tgt;
      end else begin
        d = (m.tgt - m.ph + div) % div;
        if (d == 0)            n.ph = m.ph;
        else if (d <= div / 2) n.ph = (m.ph + 1) % div;
        else                   n.ph = (m.ph + div - 1) % div;
      end
    end
    n.busy = (n.ph != n.tgt);
    return n;
  endfunction

  function automatic int mpack(input mdl_t m);
    return int'({m.slow, m.sstb, m.pstb, m.busy, m.err, 3'(m.ph)});
  endfunction

  // One clock: advance the models with the inputs seen at the edge, then compare.
  task automatic tick();
    @(posedge clk);
    m_a = mstep(m_a, 6, 1'b0, rst, a_load, int'(a_din));
    m_b = mstep(m_b, 6, 1'b1, rst, b_load, int'(b_din));
    m_c = mstep(m_c, 8, 1'b1, rst, c_load, int'(c_din));
    #1;
    chk("A vs model", int'({a_slow, a_sstb, a_pstb, a_busy, a_err, a_cur}), mpack(m_a));
    chk("B vs model", int'({b_slow, b_sstb, b_pstb, b_busy, b_err, b_cur}), mpack(m_b));
    chk("C vs model", int'({c_slow, c_sstb, c_pstb, c_busy, c_err, c_cur}), mpack(m_c));
  endtask

  typedef struct {
    bit rst;
    bit ld;
    int din;
    bit slow;
    bit sstb;
    bit pstb;
    bit busy;
    bit err;
    int cur;
  } vec_t;

  vec_t tbl[15];

  initial begin
    bit found;
    int step_exp;
    int run;
    bit prev;
    bit first;
    int seen;

    m_a = '{default: 0};
    m_b = '{default: 0};
    m_c = '{default: 0};

    // DIV=6, SLEW=0: reset pattern, load 2, then an out-of-range load of 7.
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 1, 1, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 1, 0, 0, 0, 0, 0};
    tbl[3]  = '{0, 0, 0, 1, 0, 0, 0, 0, 0};
    tbl[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[5]  = '{0, 1, 2, 0, 0, 0, 1, 0, 0};
    tbl[6]  = '{0, 0, 0, 0, 0, 1, 0, 0, 2};
    tbl[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 2};
    tbl[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 2};
    tbl[9]  = '{0, 0, 0, 1, 1, 0, 0, 0, 2};
    tbl[10] = '{0, 0, 0, 1, 0, 0, 0, 0, 2};
    tbl[11] = '{0, 0, 0, 1, 0, 0, 0, 0, 2};
    tbl[12] = '{0, 0, 0, 0, 0, 1, 0, 0, 2};
    tbl[13] = '{0, 1, 7, 0, 0, 0, 1, 1, 2};
    tbl[14] = '{0, 0, 0, 0, 0, 0, 1, 0, 2};

    for (int i = 0; i < 15; i++) begin
      rst    = tbl[i].rst;
      a_load = tbl[i].ld;
      a_din  = 3'(tbl[i].din);
      tick();
      chk($sformatf("tbl[%0d] slow", i), int'(a_slow), int'(tbl[i].slow));
      chk($sformatf("tbl[%0d] sample_stb", i), int'(a_sstb), int'(tbl[i].sstb));
      chk($sformatf("tbl[%0d] period_stb", i), int'(a_pstb), int'(tbl[i].pstb));
      chk($sformatf("tbl[%0d] busy", i), int'(a_busy), int'(tbl[i].busy));
      chk($sformatf("tbl[%0d] err", i), int'(a_err), int'(tbl[i].err));
      chk($sformatf("tbl[%0d] cur", i), int'(a_cur), tbl[i].cur);
    end
    a_load = 1'b0;

    // DIV=6, SLEW=1: 0 -> 5 is a single -1 step with wrap.
    rst = 1'b1; tick(); rst = 1'b0;
    b_load = 1'b1; b_din = 3'd5; tick(); b_load = 1'b0;
    chk("B busy after load 5", int'(b_busy), 1);
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      tick();
      if (b_pstb) found = 1'b1;
    end
    chk("B boundary reached", int'(found), 1);
    chk("B cur after one boundary", int'(b_cur), 5);
    chk("B busy cleared", int'(b_busy), 0);

    // Load 1 mid-period, then load 3 on the update cycle: the update uses target 1.
    b_load = 1'b1; b_din = 3'd1; tick(); b_load = 1'b0;
    for (int k = 0; k < 8 && m_b.cnt != 5; k++) tick();
    b_load = 1'b1; b_din = 3'd3; tick(); b_load = 1'b0;
    chk("B update used old target", int'(b_cur), 0);
    chk("B busy toward new target", int'(b_busy), 1);
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      tick();
      if (b_pstb) found = 1'b1;
    end
    chk("B second boundary reached", int'(found), 1);
    chk("B new target applied next", int'(b_cur), 1);

    // DIV=8, SLEW=1: 0 -> 4 in four +1 steps; run lengths stay within 3..5.
    rst = 1'b1; tick(); rst = 1'b0;
    c_load = 1'b1; c_din = 3'd4; tick(); c_load = 1'b0;
    step_exp = 1;
    prev = c_slow;
    run = 1;
    first = 1'b1;
    for (int k = 0; k < 44; k++) begin
      tick();
      if (c_pstb) begin
        chk("C step value", int'(c_cur), step_exp);
        if (step_exp < 4) step_exp++;
      end
      if (c_slow == prev) begin
        run++;
      end else begin
        if (!first) chk($sformatf("C run length %0d in 3..5", run), int'(run >= 3 && run <= 5), 1);
        first = 1'b0;
        run = 1;
        prev = c_slow;
      end
    end
    chk("C final cur", int'(c_cur), 4);
    chk("C final busy", int'(c_busy), 0);

    // Reset in the middle of a slew.
    rst = 1'b1; tick(); rst = 1'b0;
    c_load = 1'b1; c_din = 3'd4; tick(); c_load = 1'b0;
    seen = 0;
    for (int k = 0; k < 24 && seen < 2; k++) begin
      tick();
      if (c_pstb) seen++;
    end
    chk("C two boundaries before reset", seen, 2);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("C slow after mid-slew reset", int'(c_slow), 0);
    chk("C cur after mid-slew reset", int'(c_cur), 0);
    chk("C busy after mid-slew reset", int'(c_busy), 0);
    for (int k = 0; k < 16; k++) begin
      tick();
      chk($sformatf("C post-reset wave %0d", k), int'(c_slow), int'((k % 8) < 4));
      chk($sformatf("C post-reset cur %0d", k), int'(c_cur), 0);
    end

    // Randomised loads and occasional resets against the model.
    for (int k = 0; k < 3000; k++) begin
      rst    = ($urandom_range(0, 299) == 0);
      a_load = ($urandom_range(0, 3) == 0);
      b_load = ($urandom_range(0, 3) == 0);
      c_load = ($urandom_range(0, 5) == 0);
      a_din  = 3'($urandom_range(0, 7));
      b_din  = 3'($urandom_range(0, 7));
      c_din  = 3'($urandom_range(0, 7));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
